// File: rtl/btn_edge_bank.sv
// Multi-channel button front end. Each channel synchronises its input, debounces it and
// raises edge pulses, sticky pending flags and a long-press pulse for the IO/IRQ logic.
module btn_edge_bank #(
    parameter int                NUM_CH      = 4,
    parameter int                DB_CYCLES   = 500000,
    parameter int                HOLD_CYCLES = 100000000,
    parameter logic [NUM_CH-1:0] INIT_LEVEL  = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_CH-1:0]     IN,
    input  logic [2*NUM_CH-1:0]   EDGE_MODE,
    input  logic [NUM_CH-1:0]     CLR,
    output logic [NUM_CH-1:0]     DB_LEVEL,
    output logic [NUM_CH-1:0]     PULSE,
    output logic [NUM_CH-1:0]     HOLD,
    output logic [NUM_CH-1:0]     PEND,
    output logic                  ANY
);

    localparam int              DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [NUM_CH-1:0] s1_q, s2_q;
    logic [NUM_CH-1:0] db_level_q, db_level_d;
    logic [NUM_CH-1:0] db_prev_q;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic              any_q, any_d;
    logic [DB_W-1:0]   db_cnt_q [NUM_CH];
    logic [DB_W-1:0]   db_cnt_d [NUM_CH];

    // A level change is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_level_d = db_level_q;
        for (int i = 0; i < NUM_CH; i++) begin
            db_cnt_d[i] = '0;
            if (s2_q[i] != db_level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_level_d[i] = s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Edge seen as the debounced level against its one-cycle-old copy; mode sampled now.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pulse_d[i] = (db_level_q[i] & ~db_prev_q[i] & EDGE_MODE[2*i])
                       | (~db_level_q[i] & db_prev_q[i] & EDGE_MODE[2*i+1]);
        end
        any_d  = |pulse_d;
        pend_d = (pend_q & ~CLR) | pulse_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q       <= INIT_LEVEL;
            s2_q       <= INIT_LEVEL;
            db_level_q <= INIT_LEVEL;
            db_prev_q  <= INIT_LEVEL;
            pulse_q    <= '0;
            pend_q     <= '0;
            any_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) db_cnt_q[i] <= '0;
        end else begin
            s1_q       <= IN;
            s2_q       <= s1_q;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
            pulse_q    <= pulse_d;
            pend_q     <= pend_d;
            any_q      <= any_d;
            for (int i = 0; i < NUM_CH; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    generate
        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int                HOLD_W   = $clog2(HOLD_CYCLES + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

            logic [HOLD_W-1:0] hold_cnt_q [NUM_CH];
            logic [HOLD_W-1:0] hold_cnt_d [NUM_CH];
            logic [NUM_CH-1:0] hold_q, hold_d;

            // Counter saturates at HOLD_MAX so the pulse fires once per press.
            always_comb begin
                hold_d = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    hold_cnt_d[i] = '0;
                    if (db_level_q[i]) begin
                        if (hold_cnt_q[i] != HOLD_MAX) begin
                            hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
                            hold_d[i]     = (hold_cnt_q[i] == HOLD_MAX - HOLD_W'(1));
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i];
                        end
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    hold_q <= '0;
                    for (int i = 0; i < NUM_CH; i++) hold_cnt_q[i] <= '0;
                end else begin
                    hold_q <= hold_d;
                    for (int i = 0; i < NUM_CH; i++) hold_cnt_q[i] <= hold_cnt_d[i];
                end
            end

            assign HOLD = hold_q;
        end else begin : g_no_hold
            assign HOLD = '0;
        end
    endgenerate

    assign DB_LEVEL = db_level_q;
    assign PULSE    = pulse_q;
    assign PEND     = pend_q;
    assign ANY      = any_q;

endmodule
